// File: rtl/sfx_seq.sv
// Sound-effect sequencer: plays fixed note sequences (HIT/SCORE/WIN) with priority pre-emption.
// Zero added latency: a trigger edge updates the registered outputs on the same clk edge; no backpressure.
module sfx_seq #(
  parameter int TICK_DIV  = 2500000,
  parameter int GAP_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig_hit,
  input  logic        trig_score,
  input  logic        trig_win,
  input  logic [2:0]  volume,
  output logic [21:0] note_div,
  output logic [15:0] pos,
  output logic [15:0] neg,
  output logic        busy
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [15:0]     GAP_LAST = 16'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  localparam logic [1:0] SEQ_NONE  = 2'd0;
  localparam logic [1:0] SEQ_HIT   = 2'd1;
  localparam logic [1:0] SEQ_SCORE = 2'd2;
  localparam logic [1:0] SEQ_WIN   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

  // Sequence code doubles as priority rank, so pre-emption is a plain compare.
  function automatic logic [21:0] f_div(input logic [1:0] s, input logic [1:0] i);
    case ({s, i})
      {SEQ_HIT,   2'd0}: f_div = 22'd47755;
      {SEQ_HIT,   2'd1}: f_div = 22'd35790;
      {SEQ_SCORE, 2'd0}: f_div = 22'd75872;
      {SEQ_SCORE, 2'd1}: f_div = 22'd63775;
      {SEQ_SCORE, 2'd2}: f_div = 22'd47755;
      {SEQ_WIN,   2'd0}: f_div = 22'd95601;
      {SEQ_WIN,   2'd1}: f_div = 22'd75872;
      {SEQ_WIN,   2'd2}: f_div = 22'd63775;
      {SEQ_WIN,   2'd3}: f_div = 22'd47755;
      default:           f_div = 22'd0;
    endcase
  endfunction

  function automatic logic [15:0] f_ticks(input logic [1:0] s, input logic [1:0] i);
    case ({s, i})
      {SEQ_HIT,   2'd0}: f_ticks = 16'd2;
      {SEQ_HIT,   2'd1}: f_ticks = 16'd2;
      {SEQ_SCORE, 2'd0}: f_ticks = 16'd4;
      {SEQ_SCORE, 2'd1}: f_ticks = 16'd4;
      {SEQ_SCORE, 2'd2}: f_ticks = 16'd8;
      {SEQ_WIN,   2'd0}: f_ticks = 16'd6;
      {SEQ_WIN,   2'd1}: f_ticks = 16'd6;
      {SEQ_WIN,   2'd2}: f_ticks = 16'd6;
      {SEQ_WIN,   2'd3}: f_ticks = 16'd12;
      default:           f_ticks = 16'd1;
    endcase
  endfunction

  function automatic logic [1:0] f_last(input logic [1:0] s);
    case (s)
      SEQ_HIT:   f_last = 2'd1;
      SEQ_SCORE: f_last = 2'd2;
      SEQ_WIN:   f_last = 2'd3;
      default:   f_last = 2'd0;
    endcase
  endfunction

  state_t        r_state;
  logic [1:0]    r_seq;
  logic [1:0]    r_idx;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_tick;
  logic [2:0]    r_prev;
  logic [21:0]   r_note_div;
  logic [15:0]   r_pos;
  logic [15:0]   r_neg;
  logic          r_busy;

  logic [2:0]  w_trig;
  logic [2:0]  w_edge;
  logic [1:0]  w_req;
  logic        w_start;
  logic [15:0] w_amp;
  logic [15:0] w_amp_neg;
  logic        w_wrap;
  logic [15:0] w_cur_last;
  logic [1:0]  w_idx_nxt;
  logic [21:0] w_div_nxt;

  assign w_trig     = {trig_win, trig_score, trig_hit};
  assign w_edge     = w_trig & ~r_prev;
  assign w_req      = w_edge[2] ? SEQ_WIN :
                      w_edge[1] ? SEQ_SCORE :
                      w_edge[0] ? SEQ_HIT : SEQ_NONE;
  // r_seq is SEQ_NONE whenever idle, so any edge starts from IDLE.
  assign w_start    = (w_req != SEQ_NONE) && (w_req >= r_seq);
  assign w_amp      = {1'b0, volume, 12'h000};
  assign w_amp_neg  = 16'd0 - w_amp;
  assign w_wrap     = (r_pre == PRE_MAX);
  assign w_cur_last = f_ticks(r_seq, r_idx) - 16'd1;
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_div_nxt  = f_div(r_seq, w_idx_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_seq      <= SEQ_NONE;
      r_idx      <= 2'd0;
      r_pre      <= '0;
      r_tick     <= 16'd0;
      r_prev     <= 3'b000;
      r_note_div <= 22'd0;
      r_pos      <= 16'd0;
      r_neg      <= 16'd0;
      r_busy     <= 1'b0;
    end else begin
      r_prev <= w_trig;
      if (w_start) begin
        r_state    <= S_NOTE;
        r_seq      <= w_req;
        r_idx      <= 2'd0;
        r_pre      <= '0;
        r_tick     <= 16'd0;
        r_note_div <= f_div(w_req, 2'd0);
        r_pos      <= w_amp;
        r_neg      <= w_amp_neg;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          S_NOTE: begin
            r_pos <= w_amp;
            r_neg <= w_amp_neg;
            if (w_wrap) begin
              r_pre <= '0;
              if (r_tick == w_cur_last) begin
                r_tick <= 16'd0;
                if (r_idx == f_last(r_seq)) begin
                  r_state    <= S_IDLE;
                  r_seq      <= SEQ_NONE;
                  r_idx      <= 2'd0;
                  r_note_div <= 22'd0;
                  r_pos      <= 16'd0;
                  r_neg      <= 16'd0;
                  r_busy     <= 1'b0;
                end else if (GAP_TICKS == 0) begin
                  r_idx      <= w_idx_nxt;
                  r_note_div <= w_div_nxt;
                end else begin
                  r_state <= S_GAP;
                  r_pos   <= 16'd0;
                  r_neg   <= 16'd0;
                end
              end else begin
                r_tick <= r_tick + 16'd1;
              end
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          S_GAP: begin
            r_pos <= 16'd0;
            r_neg <= 16'd0;
            if (w_wrap) begin
              r_pre <= '0;
              if (r_tick == GAP_LAST) begin
                r_tick     <= 16'd0;
                r_state    <= S_NOTE;
                r_idx      <= w_idx_nxt;
                r_note_div <= w_div_nxt;
                r_pos      <= w_amp;
                r_neg      <= w_amp_neg;
              end else begin
                r_tick <= r_tick + 16'd1;
              end
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          default: begin
            r_note_div <= 22'd0;
            r_pos      <= 16'd0;
            r_neg      <= 16'd0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note_div = r_note_div;
  assign pos      = r_pos;
  assign neg      = r_neg;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sfx_seq.sv
// Scoreboard bench for sfx_seq at TICK_DIV=4, GAP_TICKS=1: per-cycle expectations queued at negedge, checked after posedge.
module tb_sfx_seq;

  localparam int TD = 4;
  localparam int GT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_hit = 1'b0;
  logic        trig_score = 1'b0;
  logic        trig_win = 1'b0;
  logic [2:0]  volume = 3'd2;
  logic [21:0] note_div;
  logic [15:0] pos;
  logic [15:0] neg;
  logic        busy;

  sfx_seq #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst_n(rst_n), .trig_hit(trig_hit), .trig_score(trig_score),
    .trig_win(trig_win), .volume(volume), .note_div(note_div), .pos(pos),
    .neg(neg), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] div;
    logic [15:0] p;
    logic [15:0] n;
    logic        b;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-entered sequence table: index 0 HIT, 1 SCORE, 2 WIN.
  int div_tab[3][4] = '{'{47755, 35790, 0, 0},
                        '{75872, 63775, 47755, 0},
                        '{95601, 75872, 63775, 47755}};
  int tk_tab[3][4]  = '{'{2, 2, 0, 0}, '{4, 4, 8, 0}, '{6, 6, 6, 12}};
  int n_tab[3]      = '{2, 3, 4};

  task automatic check(input string nm, input int tag, input logic [21:0] adiv, input logic [15:0] ap,
                       input logic [15:0] an, input logic ab, input logic [21:0] ediv,
                       input logic [15:0] ep, input logic [15:0] en, input logic eb);
    checks++;
    if (adiv !== ediv || ap !== ep || an !== en || ab !== eb) begin
      errors++;
      $display("FAIL %s #%0d: got div=%0d pos=%h neg=%h busy=%b, expected div=%0d pos=%h neg=%h busy=%b",
               nm, tag, adiv, ap, an, ab, ediv, ep, en, eb);
    end
  endtask

  function automatic logic [31:0] amp_of(input logic [2:0] v);
    case (v)
      3'd0:    amp_of = {16'h0000, 16'h0000};
      3'd2:    amp_of = {16'h2000, 16'hE000};
      3'd7:    amp_of = {16'h7000, 16'h9000};
      default: amp_of = {16'hDEAD, 16'hBEEF};
    endcase
  endfunction

  int cur_test = 0;

  task automatic step(input logic [2:0] trg, input logic [2:0] vol, input int ediv,
                      input logic [15:0] ep, input logic [15:0] en, input logic eb, input int c);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    {trig_win, trig_score, trig_hit} = trg;
    volume = vol;
    e.div = 22'(ediv); e.p = ep; e.n = en; e.b = eb; e.tag = cur_test * 1000 + c;
    q.push_back(e);
  endtask

  task automatic play(input int s, input logic [2:0] trg0, input logic [2:0] hold, input int inj_at,
                      input logic [2:0] inj, input int max_cyc, input logic [2:0] v0,
                      input int vat1, input logic [2:0] v1, input int vat2, input logic [2:0] v2);
    int c = 0;
    logic [2:0] v = v0;
    logic [2:0] t;
    logic [31:0] a;
    for (int k = 0; k < n_tab[s]; k++) begin
      for (int i = 0; i < tk_tab[s][k] * TD + ((k < n_tab[s] - 1) ? GT * TD : 0); i++) begin
        if (c == max_cyc) return;
        if (c == vat1) v = v1;
        if (c == vat2) v = v2;
        t = (c == 0) ? trg0 : (c == inj_at) ? inj : hold;
        a = amp_of(v);
        if (i < tk_tab[s][k] * TD) step(t, v, div_tab[s][k], a[31:16], a[15:0], 1'b1, c);
        else                       step(t, v, div_tab[s][k], 16'h0, 16'h0, 1'b1, c);
        c++;
      end
    end
    if (c == max_cyc) return;
    step(hold, v, 0, 16'h0, 16'h0, 1'b0, c);
  endtask

  task automatic idle(input logic [2:0] trg, input int n);
    for (int i = 0; i < n; i++) step(trg, 3'd2, 0, 16'h0, 16'h0, 1'b0, 900 + i);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", e.tag, note_div, pos, neg, busy, e.div, e.p, e.n, e.b);
      end
    end
  end

  initial begin : stim
    #3;
    check("reset_state", 0, note_div, pos, neg, busy, 22'd0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);

    cur_test = 1;  // single HIT pulse: 8 note, 4 gap, 8 note, then idle
    idle(3'b000, 3);
    play(0, 3'b001, 3'b000, -1, 3'b000, -1, 3'd2, -1, 3'd2, -1, 3'd2);

    cur_test = 2;  // HIT held 100 cycles fires once
    play(0, 3'b001, 3'b001, -1, 3'b000, -1, 3'd2, -1, 3'd2, -1, 3'd2);
    idle(3'b001, 79);
    idle(3'b000, 2);

    cur_test = 3;  // WIN pre-empts SCORE note 2; HIT during WIN ignored
    play(1, 3'b010, 3'b000, -1, 3'b000, 16 + 4 + 5, 3'd2, -1, 3'd2, -1, 3'd2);
    play(2, 3'b100, 3'b000, 10, 3'b001, -1, 3'd2, -1, 3'd2, -1, 3'd2);

    cur_test = 4;  // simultaneous HIT+SCORE edges: SCORE wins
    idle(3'b000, 2);
    play(1, 3'b011, 3'b000, -1, 3'b000, 6, 3'd2, -1, 3'd2, -1, 3'd2);

    cur_test = 5;  // volume changes mid-note in WIN (restarting from SCORE)
    play(2, 3'b100, 3'b000, -1, 3'b000, -1, 3'd2, 10, 3'd0, 40, 3'd7);

    cur_test = 6;  // asynchronous reset mid-WIN, then stays idle
    play(2, 3'b100, 3'b000, -1, 3'b000, 30, 3'd2, -1, 3'd2, -1, 3'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_win", 6000, note_div, pos, neg, busy, 22'd0, 16'h0, 16'h0, 1'b0);
    idle(3'b000, 10);

    cur_test = 7;  // HIT held through reset release fires on first edge
    @(negedge clk);
    rst_n = 1'b0;
    trig_hit = 1'b1;
    #1 check("reset_hold", 7000, note_div, pos, neg, busy, 22'd0, 16'h0, 16'h0, 1'b0);
    play(0, 3'b001, 3'b001, -1, 3'b000, -1, 3'd2, -1, 3'd2, -1, 3'd2);
    idle(3'b000, 2);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
